// File: rtl/osc_meas_pkg.sv
// osc_meas_pkg
//   Shared types and constants for the oscillator measurement counter.
//   - state_e    : measurement FSM states
//   - ARM_CYCLES : length of the ARM phase in CLK cycles
//   - CNT_W_DEF / WIN_W_DEF : default widths of the edge counter and window length
package osc_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam int ARM_CYCLES = 2;
    localparam int CNT_W_DEF  = 24;
    localparam int WIN_W_DEF  = 16;

endpackage

// File: rtl/osc_meas_sync.sv
// osc_meas_sync
//   Brings the asynchronous oscillator net into the CLK domain through two
//   flops, and uses a third flop as a one-cycle history for rising-edge
//   detection.
//   Ports:
//     CLK    in  reference clock
//     RN     in  synchronous active-low reset (clears all three flops)
//     flush  in  drop any pending edge: history is aligned to the newest
//                synchronized sample, so no rise is reported next cycle
//     osc_in in  buffered oscillator signal (asynchronous)
//     rise   out one-cycle pulse per detected rising edge (s2 & ~s3)
module osc_meas_sync (
    input  logic CLK,
    input  logic RN,
    input  logic flush,
    input  logic osc_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            // While flushing, s3 tracks the value entering s2 so a level that
            // was already high before the window does not look like an edge.
            s3 <= flush ? s1 : s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/osc_meas_counter.sv
// osc_meas_counter
//   Counts rising edges of the buffered ring-oscillator output over a
//   programmable number of CLK cycles and holds the result for readout with
//   a valid/ack handshake.
//   Ports:
//     CLK          in  reference clock (single domain)
//     RN           in  synchronous active-low reset
//     start        in  measurement request pulse, honoured only in IDLE
//     win_len      in  window length in CLK cycles, latched on accepted start
//     osc_in       in  oscillator signal, asynchronous to CLK
//     busy         out high in ARM and MEASURE
//     result_valid out high in HOLD
//     result_ack   in  consumer accepts the result while result_valid
//     count        out rising edges counted in the last window
//     overflow     out counter exceeded 2^CNT_W-1 during the last window
//   Build option: define OSC_MEAS_SATURATE_EN to make the counter saturate at
//   its maximum; otherwise it wraps and overflow is a sticky wrap flag.
import osc_meas_pkg::*;

module osc_meas_counter #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             osc_in,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

    state_e           state;
    logic [ARM_W-1:0] arm_cnt;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_cnt;
    logic             rise;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_hit;

    osc_meas_sync u_sync (
        .CLK    (CLK),
        .RN     (RN),
        .flush  (state == ARM),
        .osc_in (osc_in),
        .rise   (rise)
    );

    // Value of the counter after one more edge, and whether that edge
    // overflows the counter.
    always_comb begin
        cnt_next = count;
        ovf_hit  = 1'b0;
`ifdef OSC_MEAS_SATURATE_EN
        if (&count) begin
            ovf_hit = 1'b1;
        end else begin
            cnt_next = count + CNT_W'(1);
        end
`else
        {ovf_hit, cnt_next} = {1'b0, count} + {1'b0, CNT_W'(1)};
`endif
    end

    // count is the edge counter itself: it only moves in MEASURE and is
    // cleared in ARM, so it already holds steady through HOLD and IDLE.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state        <= IDLE;
            arm_cnt      <= '0;
            win_q        <= '0;
            win_cnt      <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win_q   <= win_len;
                        arm_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    count    <= '0;
                    overflow <= 1'b0;
                    win_cnt  <= win_q;
                    arm_cnt  <= arm_cnt + ARM_W'(1);
                    if (arm_cnt == ARM_LAST) begin
                        if (win_q == '0) begin
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            state        <= HOLD;
                        end else begin
                            state <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    win_cnt <= win_cnt - WIN_W'(1);
                    if (rise) begin
                        count <= cnt_next;
                        if (ovf_hit) begin
                            overflow <= 1'b1;
                        end
                    end
                    if (win_cnt == WIN_W'(1)) begin
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    // A start arriving with the ack is dropped: only IDLE
                    // looks at start.
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_meas_counter.sv
module tb_osc_meas_counter;

    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RN = 1'b0;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             osc_in = 1'b0;
    logic             busy;
    logic             result_valid;
    logic             result_ack = 1'b0;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit hist [0:99999];
    int osc_mode = 0;
    int osc_per = 8;
    int osc_phase = 0;

    osc_meas_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .CLK          (CLK),
        .RN           (RN),
        .start        (start),
        .win_len      (win_len),
        .osc_in       (osc_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 CLK = ~CLK;

    // hist[n] is the osc_in level seen at rising CLK edge number n.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (cyc < 100000) hist[cyc] = osc_in;
    end

    // osc_in changes only at falling edges; mode 1 is a square wave whose
    // rising sample falls on edges n == osc_phase (mod osc_per), mode 2 is random.
    always @(negedge CLK) begin
        int n;
        n = cyc + 1;
        case (osc_mode)
            1:       osc_in = ((n + 1000 * osc_per - osc_phase) % osc_per) < (osc_per / 2);
            2:       osc_in = 1'($urandom_range(0, 1));
            default: osc_in = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the window sees rising transitions of the sampled oscillator
    // between edges T+2 and T+w (the -2 offset plus ARM flushing), then the
    // count is folded to CNT_W bits.
    task automatic model(input int t, input int w, output int exp_cnt, output int exp_ovf);
        int edges;
        edges = 0;
        for (int j = t + 2; j <= t + w; j++)
            if (hist[j] && !hist[j-1]) edges++;
`ifdef OSC_MEAS_SATURATE_EN
        exp_cnt = (edges > MAXV) ? MAXV : edges;
`else
        exp_cnt = edges % (MAXV + 1);
`endif
        exp_ovf = (edges > MAXV) ? 1 : 0;
    endtask

    // One full measurement. The square-wave phase is chosen so a rising
    // sample lands on the first counted edge T+2.
    task automatic run_meas(input int w, input int mode, input int per,
                            input bit mid_start, input int hold_wait,
                            input bit start_with_ack, output int got_cnt);
        int t, n, exp_cnt, exp_ovf;
        osc_mode  = mode;
        osc_per   = per;
        osc_phase = (cyc + 4) % per;
        @(negedge CLK);
        start   = 1'b1;
        win_len = WIN_W'(w);
        t       = cyc + 1;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!result_valid && n < 400) begin
            start = (mid_start && n == w / 2 + 2);
            @(negedge CLK);
            n++;
        end
        start = 1'b0;
        chk("valid_latency", cyc - t, w + 2);
        chk("busy_in_hold", busy, 0);
        model(t, w, exp_cnt, exp_ovf);
        chk("count", count, exp_cnt);
        chk("overflow", overflow, exp_ovf);
        got_cnt = exp_cnt;
        for (int i = 0; i < hold_wait; i++) begin
            @(negedge CLK);
            chk("hold_valid", result_valid, 1);
            chk("hold_count", count, exp_cnt);
            chk("hold_busy", busy, 0);
        end
        result_ack = 1'b1;
        start      = start_with_ack;
        @(negedge CLK);
        result_ack = 1'b0;
        start      = 1'b0;
        chk("ack_valid_drop", result_valid, 0);
        chk("ack_busy", busy, 0);
        @(negedge CLK);
        chk("idle_busy", busy, 0);
        chk("idle_count", count, exp_cnt);
        chk("idle_overflow", overflow, exp_ovf);
    endtask

    initial begin
        int c;
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        RN = 1'b1;
        @(negedge CLK);

        // Nominal: period 8, 80-cycle window -> 10 edges
        run_meas(80, 1, 8, 1'b0, 0, 1'b0, c);
        chk("nominal_count", c, 10);

        // Zero window
        run_meas(0, 1, 4, 1'b0, 0, 1'b0, c);

        // Overflow: period 4, 100-cycle window -> 25 edges on a 4-bit counter
        run_meas(100, 1, 4, 1'b0, 0, 1'b0, c);
`ifdef OSC_MEAS_SATURATE_EN
        chk("ovf_count", c, 15);
`else
        chk("ovf_count", c, 9);
`endif

        // Handshake: ack withheld 10 cycles, start pulse during MEASURE
        run_meas(40, 1, 6, 1'b1, 10, 1'b0, c);

        // start together with ack in HOLD
        run_meas(12, 2, 2, 1'b0, 2, 1'b1, c);

        // Reset in the middle of a measurement
        osc_mode = 1;
        osc_per  = 4;
        @(negedge CLK);
        start   = 1'b1;
        win_len = WIN_W'(60);
        @(negedge CLK);
        start = 1'b0;
        repeat (20) @(negedge CLK);
        chk("pre_rst_busy", busy, 1);
        RN = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_overflow", overflow, 0);
        @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", busy, 0);
        run_meas(30, 1, 5, 1'b0, 0, 1'b0, c);

        // Randomized windows and oscillator patterns
        for (int k = 0; k < 10; k++)
            run_meas(int'($urandom_range(0, 70)), int'($urandom_range(1, 2)),
                     int'($urandom_range(2, 9)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
